// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter and its users.
// bypass_entry_t is the broadcast record; cdb_entry_t adds the ROB tag for ROB writeback.
package cdb_arbiter_pkg;

    localparam int NUM_FU         = 5;
    localparam int BYPASS_LENGTH  = 3;
    localparam int PHYS_REG_IDX_W = 6;
    localparam int INT_DATA_W     = 32;
    localparam int ROB_IDX_W      = 4;
    localparam int FU_IDX_W       = $clog2(NUM_FU);

    typedef enum logic [FU_IDX_W-1:0] {
        FU_ALU = 3'd0,
        FU_MEM = 3'd1,
        FU_MUL = 3'd2,
        FU_DIV = 3'd3,
        FU_FPU = 3'd4
    } fu_type_e;

    typedef struct packed {
        logic                      valid;
        logic [PHYS_REG_IDX_W-1:0] phys_rd;
        logic [INT_DATA_W-1:0]     result;
    } bypass_entry_t;

    typedef struct packed {
        bypass_entry_t  entry;
        logic [ROB_IDX_W:0] rob_idx;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Generic combinational round-robin picker: the search starts just after last_i and wraps.
// Also reused by issue-queue select, so it holds no state of its own.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    input  logic                 en_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = last_i;
        valid_o     = 1'b0;
        idx         = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last_i) + off) % N);
            if (en_i && !valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: grants one functional unit per cycle onto the registered CDB
// and keeps a short history of recent broadcasts for wakeup and forwarding.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush_i,
    input  logic [NUM_FU-1:0]                         fu_valid_i,
    input  logic [NUM_FU-1:0][PHYS_REG_IDX_W-1:0]     fu_phys_rd_i,
    input  logic [NUM_FU-1:0][INT_DATA_W-1:0]         fu_result_i,
    input  logic [NUM_FU-1:0][ROB_IDX_W:0]            fu_rob_idx_i,
    output logic [NUM_FU-1:0]                         fu_ready_o,
    output bypass_entry_t                             cdb_o,
    output logic [ROB_IDX_W:0]                        cdb_rob_idx_o,
    output bypass_entry_t [BYPASS_LENGTH-1:0]         bypass_o
);

    logic [FU_IDX_W-1:0] last_grant_q, last_grant_d;
    logic [FU_IDX_W-1:0] grant_idx;
    logic [NUM_FU-1:0]   grant;
    logic                grant_vld;
    logic                arb_en;
    cdb_entry_t          cdb_q, cdb_d;

    // Flush and reset both suppress grants so no unit sees a handshake it cannot complete.
    assign arb_en = ~flush_i & ~rst;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req_i       (fu_valid_i),
        .last_i      (last_grant_q),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .valid_o     (grant_vld)
    );

    assign fu_ready_o = grant;

    always_comb begin
        last_grant_d      = last_grant_q;
        cdb_d             = cdb_q;
        cdb_d.entry.valid = 1'b0;
        if (grant_vld) begin
            last_grant_d        = grant_idx;
            cdb_d.entry.valid   = 1'b1;
            cdb_d.entry.phys_rd = fu_phys_rd_i[grant_idx];
            cdb_d.entry.result  = fu_result_i[grant_idx];
            cdb_d.rob_idx       = fu_rob_idx_i[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= FU_IDX_W'(NUM_FU - 1);
            cdb_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cdb_q        <= cdb_d;
        end
    end

    assign cdb_o         = cdb_q.entry;
    assign cdb_rob_idx_o = cdb_q.rob_idx;
    assign bypass_o[0]   = cdb_q.entry;

    // History shifts every cycle so that index equals age; a flush invalidates what shifts in.
    for (genvar gi = 1; gi < BYPASS_LENGTH; gi++) begin : g_hist
        bypass_entry_t prev;
        bypass_entry_t hist_q;

        if (gi == 1) begin : g_first
            assign prev = cdb_q.entry;
        end else begin : g_rest
            assign prev = g_hist[gi-1].hist_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist_q <= '0;
            end else begin
                hist_q <= {prev.valid & ~flush_i, prev.phys_rd, prev.result};
            end
        end

        assign bypass_o[gi] = hist_q;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of grants and broadcast history.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = NUM_FU;
    localparam int BL = BYPASS_LENGTH;
    localparam int TW = ROB_IDX_W + 1;

    logic                                  clk = 1'b0;
    logic                                  rst = 1'b0;
    logic                                  flush_i;
    logic [N-1:0]                          fu_valid_i;
    logic [N-1:0][PHYS_REG_IDX_W-1:0]      fu_phys_rd_i;
    logic [N-1:0][INT_DATA_W-1:0]          fu_result_i;
    logic [N-1:0][TW-1:0]                  fu_rob_idx_i;
    logic [N-1:0]                          fu_ready_o;
    bypass_entry_t                         cdb_o;
    logic [TW-1:0]                         cdb_rob_idx_o;
    bypass_entry_t [BL-1:0]                bypass_o;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .fu_valid_i    (fu_valid_i),
        .fu_phys_rd_i  (fu_phys_rd_i),
        .fu_result_i   (fu_result_i),
        .fu_rob_idx_i  (fu_rob_idx_i),
        .fu_ready_o    (fu_ready_o),
        .cdb_o         (cdb_o),
        .cdb_rob_idx_o (cdb_rob_idx_o),
        .bypass_o      (bypass_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: pointer as a plain integer, history as an age-indexed array.
    int            m_last;
    bypass_entry_t m_hist [BL];
    logic [TW-1:0] m_rob;
    int            wait_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] v, input logic fl, input int last);
        if (fl) return -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_rob  = '0;
        for (int k = 0; k < BL; k++) m_hist[k] = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    task automatic set_unit(input int i, input logic v, input logic [PHYS_REG_IDX_W-1:0] rd,
                            input logic [INT_DATA_W-1:0] res, input logic [TW-1:0] tag);
        fu_valid_i[i]   = v;
        fu_phys_rd_i[i] = rd;
        fu_result_i[i]  = res;
        fu_rob_idx_i[i] = tag;
    endtask

    task automatic new_data(input int i);
        fu_phys_rd_i[i] = PHYS_REG_IDX_W'($urandom);
        fu_result_i[i]  = $urandom;
        fu_rob_idx_i[i] = TW'($urandom);
    endtask

    // One clock: check the combinational grant, advance the model, check registered outputs.
    task automatic step(output int w);
        bypass_entry_t nc;
        logic [TW-1:0] nrob;
        logic          fl;
        int            max_wait;
        #1;
        fl = flush_i;
        w  = model_winner(fu_valid_i, fl, m_last);
        chk("fu_ready_o", 64'(fu_ready_o), (w < 0) ? 64'd0 : (64'd1 << w));
        if (w >= 0) begin
            nc.valid   = 1'b1;
            nc.phys_rd = fu_phys_rd_i[w];
            nc.result  = fu_result_i[w];
            nrob       = fu_rob_idx_i[w];
        end else begin
            nc       = m_hist[0];
            nc.valid = 1'b0;
            nrob     = m_rob;
        end
        max_wait = 0;
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = (fu_valid_i[i] && w != i && !fl) ? wait_cnt[i] + 1 : 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        chk("fairness_wait_ge_N", 64'(max_wait >= N), 64'd0);
        @(posedge clk);
        if (w >= 0) m_last = w;
        for (int k = BL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = nc;
        m_rob     = nrob;
        if (fl) for (int k = 0; k < BL; k++) m_hist[k].valid = 1'b0;
        #1;
        chk("cdb_o", 64'(cdb_o), 64'(m_hist[0]));
        chk("cdb_rob_idx_o", 64'(cdb_rob_idx_o), 64'(m_rob));
        for (int k = 0; k < BL; k++)
            chk($sformatf("bypass_o[%0d]", k), 64'(bypass_o[k]), 64'(m_hist[k]));
    endtask

    initial begin
        int w;
        int cnt3;

        flush_i      = 1'b0;
        fu_valid_i   = '0;
        fu_phys_rd_i = '0;
        fu_result_i  = '0;
        fu_rob_idx_i = '0;
        model_reset();

        // Reset: grants blocked even with every unit requesting.
        #1 rst = 1'b1;
        fu_valid_i = '1;
        #2;
        chk("reset_ready", 64'(fu_ready_o), 64'd0);
        chk("reset_cdb", 64'(cdb_o), 64'd0);
        chk("reset_rob", 64'(cdb_rob_idx_o), 64'd0);
        for (int k = 0; k < BL; k++) chk("reset_bypass", 64'(bypass_o[k]), 64'd0);
        fu_valid_i = '0;
        @(negedge clk) rst = 1'b0;

        // All five units continuously valid: 0,1,2,3,4,0,...
        for (int i = 0; i < N; i++)
            set_unit(i, 1'b1, PHYS_REG_IDX_W'(10 + i), 32'h1000_0000 + i, TW'(i));
        for (int c = 0; c < 2 * N; c++) begin
            step(w);
            chk("rr_order", 64'(w), 64'(c % N));
            chk("rr_cdb_rd", 64'(cdb_o.phys_rd), 64'(10 + (c % N)));
        end

        // Units 1 and 2 held: 1, 2, 1.
        fu_valid_i = 5'b00110;
        step(w); chk("hold12_g0", 64'(w), 64'd1); chk("hold12_cdb0", 64'(cdb_o.result), 64'h1000_0001);
        step(w); chk("hold12_g1", 64'(w), 64'd2); chk("hold12_cdb1", 64'(cdb_o.result), 64'h1000_0002);
        step(w); chk("hold12_g2", 64'(w), 64'd1); chk("hold12_cdb2", 64'(cdb_o.result), 64'h1000_0001);
        fu_valid_i = '0;
        step(w);

        // Single ALU result walking through the history.
        set_unit(0, 1'b1, 6'd7, 32'hDEAD_BEEF, 5'h13);
        step(w);
        fu_valid_i = '0;
        chk("alu_cdb_valid", 64'(cdb_o.valid), 64'd1);
        chk("alu_cdb_rd", 64'(cdb_o.phys_rd), 64'd7);
        chk("alu_cdb_res", 64'(cdb_o.result), 64'hDEAD_BEEF);
        chk("alu_cdb_rob", 64'(cdb_rob_idx_o), 64'h13);
        step(w);
        chk("alu_n2_cdb_valid", 64'(cdb_o.valid), 64'd0);
        chk("alu_n2_byp1", 64'(bypass_o[1]), {25'd0, 1'b1, 6'd7, 32'hDEAD_BEEF});
        step(w);
        chk("alu_n3_byp2", 64'(bypass_o[2]), {25'd0, 1'b1, 6'd7, 32'hDEAD_BEEF});
        chk("alu_n3_byp1_valid", 64'(bypass_o[1].valid), 64'd0);
        step(w);
        chk("alu_n4_valids", 64'({cdb_o.valid, bypass_o[1].valid, bypass_o[2].valid}), 64'd0);

        // Flush with units 2 and 4 valid, after a broadcast from unit 3.
        set_unit(3, 1'b1, 6'd33, 32'h3333_3333, 5'h03);
        step(w);
        fu_valid_i = 5'b10100;
        flush_i    = 1'b1;
        step(w);
        chk("flush_grant", 64'(w), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_cdb_valid", 64'(cdb_o.valid), 64'd0);
        for (int k = 0; k < BL; k++) chk("flush_bypass_valid", 64'(bypass_o[k].valid), 64'd0);
        flush_i = 1'b0;
        step(w);
        chk("flush_last_kept", 64'(w), 64'd4);
        fu_valid_i = '0;
        step(w);

        // Unit 3 waits while unit 0 wins: broadcast exactly once.
        set_unit(0, 1'b1, 6'd1, 32'h0000_0A0A, 5'h01);
        set_unit(3, 1'b1, 6'd3, 32'h0303_0303, 5'h0A);
        cnt3 = 0;
        for (int c = 0; c < 5; c++) begin
            step(w);
            if (c == 0) chk("u3_first_winner", 64'(w), 64'd0);
            if (w >= 0) fu_valid_i[w] = 1'b0;
            if (cdb_o.valid && cdb_rob_idx_o == 5'h0A) cnt3++;
        end
        chk("u3_broadcast_count", 64'(cnt3), 64'd1);

        // Random traffic; units hold data until granted and drop valids after a flush.
        for (int c = 0; c < 400; c++) begin
            flush_i = ($urandom_range(15) == 0);
            step(w);
            for (int i = 0; i < N; i++) begin
                if (flush_i) begin
                    fu_valid_i[i] = 1'b0;
                end else if (w == i) begin
                    fu_valid_i[i] = ($urandom_range(2) != 0);
                    new_data(i);
                end else if (!fu_valid_i[i] && $urandom_range(1) == 1) begin
                    fu_valid_i[i] = 1'b1;
                    new_data(i);
                end
            end
            flush_i = 1'b0;
        end

        // Asynchronous reset mid-cycle during traffic.
        fu_valid_i = '1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(fu_ready_o), 64'd0);
        chk("async_rst_cdb", 64'(cdb_o), 64'd0);
        chk("async_rst_rob", 64'(cdb_rob_idx_o), 64'd0);
        for (int k = 0; k < BL; k++) chk("async_rst_bypass", 64'(bypass_o[k]), 64'd0);
        model_reset();
        fu_valid_i = '0;
        @(negedge clk) rst = 1'b0;
        fu_valid_i = 5'b10001;
        #1;
        chk("post_rst_ready", 64'(fu_ready_o), 64'b00001);
        step(w);
        fu_valid_i[0] = 1'b0;
        step(w);
        chk("post_rst_second", 64'(w), 64'd4);
        fu_valid_i = '0;
        step(w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
